// File: rtl/dm_bus_pkg.sv
// Shared constants and helpers for the two-master data-memory / MMIO arbiter.
package dm_bus_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 32;
  localparam int IO_LIMIT_DEF = 16;
  localparam int IO_TMO_DEF   = 15;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEM_RSP = 2'd1;
  localparam logic [1:0] ST_IO_WAIT = 2'd2;

  // Word addresses below the limit belong to the MMIO window.
  function automatic logic is_io(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// One requester port of the data-memory arbiter: request/grant plus completion.
interface dm_bus_arbiter_if
  import dm_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dm_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Shares the data RAM and MMIO window between the CPU (m0) and debug/DMA (m1) ports,
// with one outstanding transaction and an ack/timeout handshake on the IO side.
module dm_bus_arbiter
  import dm_bus_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter int            IO_LIMIT = IO_LIMIT_DEF,
  parameter int            IO_TMO   = IO_TMO_DEF,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic          clk,
  input  logic          rstn,
  dm_bus_arbiter_if.slave m0,
  dm_bus_arbiter_if.slave m1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_dout,
  output logic          io_we,
  output logic          io_rd,
  input  logic [DW-1:0] io_din,
  input  logic          io_ack,
  output logic          io_err
);

  localparam int CW = $clog2(IO_TMO + 1);

  logic [1:0]    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] io_addr_q, io_addr_d;
  logic [DW-1:0] io_dout_q, io_dout_d;
  logic          io_we_q, io_we_d;
  logic          io_rd_q, io_rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [1:0]    win;
  logic [1:0]    gnt;
  logic          win_idx;
  logic          sel_we;
  logic          sel_io;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          done;
  logic [DW-1:0] done_data;

  rr_arb2 u_arb (
    .req  ({m1.req, m0.req}),
    .last (last_gnt_q),
    .gnt  (win)
  );

  assign win_idx   = win[1];
  assign sel_we    = win_idx ? m1.we    : m0.we;
  assign sel_addr  = win_idx ? m1.addr  : m0.addr;
  assign sel_wdata = win_idx ? m1.wdata : m0.wdata;
  assign sel_io    = is_io(32'(sel_addr), 32'(IO_LIMIT));

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    io_addr_d  = io_addr_q;
    io_dout_d  = io_dout_q;
    io_we_d    = io_we_q;
    io_rd_d    = io_rd_q;
    cnt_d      = cnt_q;
    gnt        = 2'b00;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    done_data  = '0;
    io_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|win) begin
          gnt        = win;
          last_gnt_d = win_idx;
          owner_d    = win_idx;
          we_d       = sel_we;
          if (sel_io) begin
            io_addr_d = sel_addr;
            io_dout_d = sel_wdata;
            io_we_d   = sel_we;
            io_rd_d   = ~sel_we;
            cnt_d     = '0;
            state_d   = ST_IO_WAIT;
          end else begin
            // RAM is strobed in the grant cycle; its registered read lands next cycle.
            mem_en    = 1'b1;
            mem_we    = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
            state_d   = ST_MEM_RSP;
          end
        end
      end
      ST_MEM_RSP: begin
        done      = 1'b1;
        done_data = we_q ? '0 : mem_rdata;
        state_d   = ST_IDLE;
      end
      ST_IO_WAIT: begin
        if (io_ack) begin
          done      = 1'b1;
          done_data = we_q ? '0 : io_din;
          io_we_d   = 1'b0;
          io_rd_d   = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == CW'(IO_TMO)) begin
          done      = 1'b1;
          done_data = we_q ? '0 : ERR_DATA;
          io_err    = 1'b1;
          io_we_d   = 1'b0;
          io_rd_d   = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data stays on the port between completions.
  assign rdata0_d = (done & ~owner_q) ? done_data : rdata0_q;
  assign rdata1_d = (done &  owner_q) ? done_data : rdata1_q;

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = done & ~owner_q;
  assign m1.rvalid = done &  owner_q;
  assign m0.rdata  = rdata0_d;
  assign m1.rdata  = rdata1_d;

  assign io_addr = io_addr_q;
  assign io_dout = io_dout_q;
  assign io_we   = io_we_q;
  assign io_rd   = io_rd_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      io_addr_q  <= '0;
      io_dout_q  <= '0;
      io_we_q    <= 1'b0;
      io_rd_q    <= 1'b0;
      cnt_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      io_addr_q  <= io_addr_d;
      io_dout_q  <= io_dout_d;
      io_we_q    <= io_we_d;
      io_rd_q    <= io_rd_d;
      cnt_q      <= cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: directed vector table, corner sequences,
// and a randomized two-port run checked against an array-based memory/IO model.
module tb_dm_bus_arbiter;
  import dm_bus_pkg::*;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        men, mwe, iowe, iord, err;
    logic [7:0]  ioa;
    logic [31:0] iod;
  } res_t;

  typedef struct {
    int          port;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          ack_d;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        exp_men, exp_iowe, exp_iord;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dm_bus_arbiter_if #(.AW(8), .DW(32)) m0_if ();
  dm_bus_arbiter_if #(.AW(8), .DW(32)) m1_if ();

  logic        mem_en, mem_we, io_we, io_rd, io_ack, io_err;
  logic [7:0]  mem_addr, io_addr;
  logic [31:0] mem_wdata, mem_rdata, io_dout, io_din;

  logic [1:0]  req_v = 2'b00;
  logic [1:0]  we_v = 2'b00;
  logic [7:0]  addr_v [2];
  logic [31:0] wdata_v [2];
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o [2];

  assign m0_if.req = req_v[0];  assign m1_if.req = req_v[1];
  assign m0_if.we  = we_v[0];   assign m1_if.we  = we_v[1];
  assign m0_if.addr = addr_v[0];  assign m1_if.addr = addr_v[1];
  assign m0_if.wdata = wdata_v[0]; assign m1_if.wdata = wdata_v[1];
  assign gnt_o    = {m1_if.gnt, m0_if.gnt};
  assign rvalid_o = {m1_if.rvalid, m0_if.rvalid};
  assign rdata_o[0] = m0_if.rdata;
  assign rdata_o[1] = m1_if.rdata;

  dm_bus_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .io_ack    (io_ack),
    .io_err    (io_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_init(input int i);
    return (i == 64) ? 32'h1234_5678 : (32'hA000_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] io_init(input int i);
    return 32'hC000_0000 | 32'(i);
  endfunction

  // Environment: single-port RAM with registered read, refilled while in reset
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Environment: IO device acking after a programmable number of strobe cycles
  logic [31:0] io_regs [16];
  bit io_auto = 1'b1, rand_ack = 1'b0, io_force = 1'b0;
  int ack_delay = 0;
  initial begin
    int age, cur_delay;
    age = 0; cur_delay = 0;
    io_ack = 1'b0; io_din = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (!rstn) for (int i = 0; i < 16; i++) io_regs[i] = io_init(i);
      if (io_we || io_rd) begin
        if (age == 0) cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
        io_din = io_regs[io_addr[3:0]];
        io_ack = io_force || (io_auto && age == cur_delay);
        if (io_ack && io_we) io_regs[io_addr[3:0]] = io_dout;
        age++;
      end else begin
        io_ack = io_force;
        io_din = 32'h0BAD_0000;
        age = 0;
      end
    end
  end

  // Reference model: memory and IO contents as plain arrays
  logic [31:0] ref_ram [256];
  logic [31:0] ref_io [16];
  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_ram[i] = ram_init(i);
    for (int i = 0; i < 16; i++) ref_io[i] = io_init(i);
  endtask

  // Arbitration observer: ties go to the port that did not win last; one completion per grant
  bit mon_on = 1'b0;
  initial begin
    int last_w, w;
    bit pend [2];
    last_w = 1; pend[0] = 0; pend[1] = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_w = 1; pend[0] = 0; pend[1] = 0;
      end else begin
        for (int p = 0; p < 2; p++)
          if (rvalid_o[p]) begin
            if (mon_on) chk($sformatf("rvalid_has_grant_p%0d", p), 32'(pend[p]), 32'd1);
            pend[p] = 0;
          end
        if (gnt_o != 2'b00) begin
          if (mon_on) chk("single_grant", 32'(gnt_o == 2'b11), 32'd0);
          w = gnt_o[1] ? 1 : 0;
          if (mon_on && req_v == 2'b11) chk("rr_tie_winner", 32'(w), 32'(1 - last_w));
          last_w = w;
          pend[w] = 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; req_v = 2'b00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    ref_init();
  endtask

  task automatic do_txn(input int p, input logic we, input logic [7:0] a,
                        input logic [31:0] wd, output res_t r);
    int g;
    bit got, seen_io;
    r = '{lat: -1, rd: 32'hx, men: 0, mwe: 0, iowe: 0, iord: 0, err: 0, ioa: 0, iod: 0};
    @(posedge clk); #1;
    req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = wd;
    got = 0; seen_io = 0; g = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt_o[p]) begin
        got = 1; g = cyc; r.men = mem_en; r.mwe = mem_we;
        if (mem_en) chk($sformatf("mem_addr_p%0d", p), 32'(mem_addr), 32'(a));
      end
    end
    @(posedge clk); #1 req_v[p] = 1'b0;
    if (!got) begin
      chk($sformatf("gnt_timeout_p%0d", p), 32'd0, 32'd1);
      return;
    end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((io_we || io_rd) && !seen_io) begin
        seen_io = 1; r.ioa = io_addr; r.iod = io_dout;
      end
      r.iowe |= io_we; r.iord |= io_rd; r.err |= io_err;
      if (rvalid_o[p]) begin
        got = 1; r.lat = cyc - g; r.rd = rdata_o[p];
      end
    end
    if (!got) chk($sformatf("rvalid_timeout_p%0d", p), 32'd0, 32'd1);
  endtask

  task automatic rand_port(input int p, input int n);
    logic we;
    logic [7:0] a;
    logic [31:0] wd, exp;
    res_t r;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(16, 47));
      wd = $urandom;
      do_txn(p, we, a, wd, r);
      exp = we ? 32'h0 : ((a < 8'd16) ? ref_io[a[3:0]] : ref_ram[a]);
      chk($sformatf("rand_rdata_p%0d_a%02h", p, a), r.rd, exp);
      chk($sformatf("rand_ram_strobe_p%0d_a%02h", p, a), 32'(r.men), 32'(a >= 8'd16));
      if (a < 8'd16) chk($sformatf("rand_io_lat_p%0d", p), 32'(r.lat >= 1 && r.lat <= 4), 32'd1);
      else           chk($sformatf("rand_ram_lat_p%0d", p), 32'(r.lat), 32'd1);
      if (we) begin
        if (a < 8'd16) ref_io[a[3:0]] = wd;
        else           ref_ram[a] = wd;
      end
    end
  endtask

  vec_t vecs [9];
  res_t r;
  int   gp [4];
  int   gc [4];
  int   ng, t0;

  initial begin
    vecs[0] = '{0, 1'b0, 8'h40, 32'h0,  0, 1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1, 1'b1, 8'h02, 32'hA5, 3, 4, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 1'b0, 8'h02, 32'h0,  0, 1, 32'hA5,        1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 1'b1, 8'h0F, 32'h11, 1, 2, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 1'b1, 8'h10, 32'h22, 0, 1, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, 1'b0, 8'h10, 32'h0,  0, 1, 32'h22,        1'b1, 1'b0, 1'b0};
    vecs[6] = '{0, 1'b0, 8'h0F, 32'h0,  2, 3, 32'h11,        1'b0, 1'b0, 1'b1};
    vecs[7] = '{1, 1'b0, 8'hFF, 32'h0,  0, 1, 32'hA000_00FF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{0, 1'b0, 8'h00, 32'h0,  0, 1, 32'hC000_0000, 1'b0, 1'b0, 1'b1};
    addr_v[0] = 0; addr_v[1] = 0; wdata_v[0] = 0; wdata_v[1] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    ref_init();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_strobes", 32'({mem_en, io_we, io_rd, io_err}), 32'd0);
    chk("rst_rdata0", rdata_o[0], 32'd0);
    chk("rst_rdata1", rdata_o[1], 32'd0);
    $display("txn reset: outputs idle");

    // Both ports hammer RAM from reset: m0 first, then alternate every 2 cycles
    @(posedge clk); #1;
    we_v = 2'b00; addr_v[0] = 8'h80; addr_v[1] = 8'h81; req_v = 2'b11;
    t0 = cyc; ng = 0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt_o != 2'b00) begin
        gp[ng] = gnt_o[1] ? 1 : 0; gc[ng] = cyc; ng++;
      end
    end
    @(posedge clk); #1 req_v = 2'b00;
    chk("rr_grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("rr_grant%0d_port", k), 32'(gp[k]), 32'(k % 2));
      chk($sformatf("rr_grant%0d_cycle", k), 32'(gc[k] - t0), 32'(2 * k));
      $display("txn rr grant %0d: port %0d at +%0d", k, gp[k], gc[k] - t0);
    end
    repeat (2) @(posedge clk);

    // Vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ack_delay = vecs[i].ack_d;
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd, r);
      chk($sformatf("v%0d_latency", i), 32'(r.lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), r.rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_mem_en", i), 32'(r.men), 32'(vecs[i].exp_men));
      chk($sformatf("v%0d_mem_we", i), 32'(r.mwe), 32'(vecs[i].exp_men & vecs[i].we));
      chk($sformatf("v%0d_io_we", i), 32'(r.iowe), 32'(vecs[i].exp_iowe));
      chk($sformatf("v%0d_io_rd", i), 32'(r.iord), 32'(vecs[i].exp_iord));
      if (vecs[i].exp_iowe || vecs[i].exp_iord) chk($sformatf("v%0d_io_addr", i), 32'(r.ioa), 32'(vecs[i].addr));
      if (vecs[i].exp_iowe) chk($sformatf("v%0d_io_dout", i), r.iod, vecs[i].wd);
      $display("txn vec %0d: m%0d we=%0b addr=%02h lat=%0d rdata=%h", i, vecs[i].port,
               vecs[i].we, vecs[i].addr, r.lat, r.rd);
    end

    // IO timeout: error pulse, ERR_DATA, held afterwards
    io_auto = 1'b0;
    do_txn(0, 1'b0, 8'h05, 32'h0, r);
    chk("tmo_latency", 32'(r.lat), 32'd16);
    chk("tmo_rdata", r.rd, ERR_DATA_DEF);
    chk("tmo_io_err", 32'(r.err), 32'd1);
    $display("txn timeout: m0 read 05 lat=%0d rdata=%h", r.lat, r.rd);
    @(negedge clk);
    chk("tmo_err_pulse", 32'(io_err), 32'd0);
    chk("tmo_strobes_off", 32'({io_we, io_rd}), 32'd0);
    repeat (2) @(negedge clk);
    chk("tmo_rdata_hold", rdata_o[0], ERR_DATA_DEF);
    chk("tmo_no_rvalid", 32'(rvalid_o), 32'd0);

    // Stray io_ack while idle must not complete anything
    io_auto = 1'b1; io_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("late_ack_no_rvalid%0d", i), 32'(rvalid_o), 32'd0);
    end
    io_force = 1'b0;
    @(negedge clk);
    $display("txn late ack: ignored");

    // Reset while waiting on IO
    io_auto = 1'b0;
    @(posedge clk); #1;
    we_v[1] = 1'b0; addr_v[1] = 8'h03; req_v[1] = 1'b1;
    ng = 0;
    for (int i = 0; i < 10 && ng == 0; i++) begin
      @(negedge clk);
      if (gnt_o[1]) ng = 1;
    end
    chk("rstio_gnt", 32'(ng), 32'd1);
    @(posedge clk); #1 req_v[1] = 1'b0;
    @(negedge clk);
    chk("rstio_io_rd_before", 32'(io_rd), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rstio_strobes_cleared", 32'({io_we, io_rd}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rstio_no_rvalid%0d", i), 32'(rvalid_o), 32'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    ref_init();
    io_auto = 1'b1;
    do_txn(1, 1'b0, 8'h40, 32'h0, r);
    chk("rstio_next_latency", 32'(r.lat), 32'd1);
    chk("rstio_next_rdata", r.rd, 32'h1234_5678);
    $display("txn reset mid-IO: next m1 read lat=%0d rdata=%h", r.lat, r.rd);

    // Randomized contention against the array model
    do_reset();
    rand_ack = 1'b1; mon_on = 1'b1;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    mon_on = 1'b0;
    $display("txn random: 80 transactions done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
